// File: rtl/ahbl_pkg.sv
// Shared constants, command entry layout and legality check for the AHB-Lite master.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // One queued command; err is decided once at push time so later stages never re-check it.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        err;
    } cmd_entry_t;

    // Returns 1 when the size/alignment pair cannot be issued as a single AHB transfer.
    function automatic logic cmd_illegal(input logic [2:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size > HSIZE_WORD) begin
            bad = 1'b1;
        end else if (size == HSIZE_HALF && addr_lo[0] != 1'b0) begin
            bad = 1'b1;
        end else if (size == HSIZE_WORD && addr_lo != 2'b00) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/ahbl_if.sv
// AHB-Lite bus signals between this master and the decoder/slaves.
interface ahbl_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        input  HREADY, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        output HREADY, HRDATA
    );

endinterface

// File: rtl/ahbl_cmd_fifo.sv
// Command FIFO holding pre-checked entries ahead of the address stage.
module ahbl_cmd_fifo
    import ahbl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  cmd_entry_t push_data,
    input  logic       pop,
    output cmd_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    cmd_entry_t      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CW'(1);
        end
    end

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and registered full flag; full is forced high in reset so nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
        end
    end

endmodule

// File: rtl/ahbl_master.sv
// AHB-Lite master: command FIFO feeding an address stage and a data stage, in-order responses.
module ahbl_master
    import ahbl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    ahbl_if.master      bus
);

    cmd_entry_t  push_data;
    cmd_entry_t  head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    logic        a_valid;
    logic        a_err;
    logic        a_write;
    logic [31:0] a_wdata;
    logic [31:0] haddr_q;
    logic [2:0]  hsize_q;
    logic        hwrite_q;

    logic        d_valid;
    logic        d_err;
    logic        d_write;
    logic [31:0] d_wdata;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    // The whole pipeline only moves on HREADY, so the A stage never fills during a stall.
    assign pop       = bus.HREADY && !fifo_empty;

    assign push_data.addr  = cmd_addr;
    assign push_data.write = cmd_write;
    assign push_data.size  = cmd_size;
    assign push_data.wdata = cmd_wdata;
    assign push_data.err   = cmd_illegal(cmd_size, cmd_addr[1:0]);

    ahbl_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.HTRANS = (a_valid && !a_err) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR  = haddr_q;
    assign bus.HSIZE  = hsize_q;
    assign bus.HWRITE = hwrite_q;
    assign bus.HWDATA = d_wdata;

    // Address stage: reload from the FIFO head whenever the bus accepts; error entries leave the bus controls untouched.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid  <= 1'b0;
            a_err    <= 1'b0;
            a_write  <= 1'b0;
            a_wdata  <= '0;
            haddr_q  <= '0;
            hsize_q  <= '0;
            hwrite_q <= 1'b0;
        end else if (bus.HREADY) begin
            a_valid <= !fifo_empty;
            if (!fifo_empty) begin
                a_err   <= head.err;
                a_write <= head.write;
                a_wdata <= head.wdata;
                if (!head.err) begin
                    haddr_q  <= head.addr;
                    hsize_q  <= head.size;
                    hwrite_q <= head.write;
                end
            end
        end
    end

    // Data stage: take over the address stage on HREADY; write data only changes for real writes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            d_valid <= 1'b0;
            d_err   <= 1'b0;
            d_write <= 1'b0;
            d_wdata <= '0;
        end else if (bus.HREADY) begin
            d_valid <= a_valid;
            d_err   <= a_err;
            d_write <= a_write;
            if (a_valid && !a_err && a_write) begin
                d_wdata <= a_wdata;
            end
        end
    end

    // Response register: one pulse per retiring data stage, read data only for legal reads.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (bus.HREADY && d_valid) begin
                rsp_valid <= 1'b1;
                rsp_write <= d_write;
                rsp_err   <= d_err;
                rsp_rdata <= (d_err || d_write) ? 32'h0 : bus.HRDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_master.sv
// Directed self-checking bench for ahbl_master with hand-computed expectations.
module tb_ahbl_master;
    import ahbl_pkg::*;

    logic        HCLK;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    int total;
    int bad;
    int accepted;

    ahbl_if bus ();

    ahbl_master #(
        .FIFO_DEPTH (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .bus       (bus)
    );

    // Free-running bus clock.
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] a, input logic w,
                                  input logic [2:0] s, input logic [31:0] d);
        cmd_valid = v;
        cmd_addr  = a;
        cmd_write = w;
        cmd_size  = s;
        cmd_wdata = d;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed sequence covering reset, latency, throughput, stalls, errors, backpressure and flush.
    initial begin
        total = 0;
        bad = 0;
        accepted = 0;
        HRESET = 1'b1;
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h0;
        apply_stimulus(1'b0, 32'h0, 1'b0, HSIZE_BYTE, 32'h0);

        $display("[TB] reset values");
        tick();
        tick();
        check_output("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_output("rst_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        check_output("rst_haddr", bus.HADDR, 32'h0);
        check_output("rst_hsize", 32'(bus.HSIZE), 32'd0);
        check_output("rst_hwrite", 32'(bus.HWRITE), 32'd0);
        check_output("rst_hwdata", bus.HWDATA, 32'h0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_rsp_rdata", rsp_rdata, 32'h0);
        HRESET = 1'b0;
        tick();
        check_output("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("[TB] single word write latency");
        apply_stimulus(1'b1, 32'h4000_0010, 1'b1, HSIZE_WORD, 32'h1234_5678);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, HSIZE_BYTE, 32'h0);
        check_output("w1_t0_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        tick();
        check_output("w1_t1_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        check_output("w1_t1_haddr", bus.HADDR, 32'h4000_0010);
        check_output("w1_t1_hsize", 32'(bus.HSIZE), 32'(HSIZE_WORD));
        check_output("w1_t1_hwrite", 32'(bus.HWRITE), 32'd1);
        tick();
        check_output("w1_t2_hwdata", bus.HWDATA, 32'h1234_5678);
        check_output("w1_t2_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        check_output("w1_t2_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        check_output("w1_t3_rsp_valid", 32'(rsp_valid), 32'd1);
        check_output("w1_t3_rsp_err", 32'(rsp_err), 32'd0);
        check_output("w1_t3_rsp_write", 32'(rsp_write), 32'd1);
        check_output("w1_t3_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        check_output("w1_t4_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("[TB] back-to-back read/write/read");
        apply_stimulus(1'b1, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        apply_stimulus(1'b1, 32'h4, 1'b1, HSIZE_WORD, 32'hA5A5_A5A5);
        tick();
        apply_stimulus(1'b1, 32'h8, 1'b0, HSIZE_WORD, 32'h0);
        check_output("b2b_a0_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        check_output("b2b_a0_haddr", bus.HADDR, 32'h0);
        check_output("b2b_a0_hwrite", 32'(bus.HWRITE), 32'd0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, HSIZE_BYTE, 32'h0);
        bus.HRDATA = 32'h1111_1111;
        check_output("b2b_a1_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        check_output("b2b_a1_haddr", bus.HADDR, 32'h4);
        check_output("b2b_a1_hwrite", 32'(bus.HWRITE), 32'd1);
        tick();
        bus.HRDATA = 32'h2222_2222;
        check_output("b2b_a2_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        check_output("b2b_a2_haddr", bus.HADDR, 32'h8);
        check_output("b2b_d1_hwdata", bus.HWDATA, 32'hA5A5_A5A5);
        check_output("b2b_r0_valid", 32'(rsp_valid), 32'd1);
        check_output("b2b_r0_write", 32'(rsp_write), 32'd0);
        check_output("b2b_r0_rdata", rsp_rdata, 32'h1111_1111);
        tick();
        bus.HRDATA = 32'h3333_3333;
        check_output("b2b_idle_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        check_output("b2b_r1_valid", 32'(rsp_valid), 32'd1);
        check_output("b2b_r1_write", 32'(rsp_write), 32'd1);
        check_output("b2b_r1_rdata", rsp_rdata, 32'h0);
        tick();
        check_output("b2b_r2_valid", 32'(rsp_valid), 32'd1);
        check_output("b2b_r2_write", 32'(rsp_write), 32'd0);
        check_output("b2b_r2_rdata", rsp_rdata, 32'h3333_3333);
        tick();
        check_output("b2b_end_valid", 32'(rsp_valid), 32'd0);

        $display("[TB] read with data-phase stall");
        bus.HRDATA = 32'h0;
        apply_stimulus(1'b1, 32'h100, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, HSIZE_BYTE, 32'h0);
        tick();
        check_output("stl_a_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        check_output("stl_a_haddr", bus.HADDR, 32'h100);
        tick();
        bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("stl_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
            check_output("stl_haddr", bus.HADDR, 32'h100);
            check_output("stl_hwrite", 32'(bus.HWRITE), 32'd0);
            check_output("stl_hwdata", bus.HWDATA, 32'hA5A5_A5A5);
            check_output("stl_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'hDEAD_BEEF;
        tick();
        check_output("stl_rsp_valid_rel", 32'(rsp_valid), 32'd1);
        check_output("stl_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check_output("stl_rsp_err", 32'(rsp_err), 32'd0);

        $display("[TB] misaligned halfword between legal commands");
        apply_stimulus(1'b1, 32'h200, 1'b1, HSIZE_WORD, 32'h0000_0077);
        tick();
        apply_stimulus(1'b1, 32'h3, 1'b0, HSIZE_HALF, 32'h0);
        check_output("err_rsp_idle", 32'(rsp_valid), 32'd0);
        tick();
        apply_stimulus(1'b1, 32'h204, 1'b0, HSIZE_WORD, 32'h0);
        check_output("err_w_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        check_output("err_w_haddr", bus.HADDR, 32'h200);
        check_output("err_w_hwrite", 32'(bus.HWRITE), 32'd1);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, HSIZE_BYTE, 32'h0);
        bus.HRDATA = 32'h0000_0099;
        check_output("err_bubble_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        check_output("err_bubble_haddr", bus.HADDR, 32'h200);
        check_output("err_w_hwdata", bus.HWDATA, 32'h0000_0077);
        tick();
        bus.HRDATA = 32'hCAFE_F00D;
        check_output("err_r_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        check_output("err_r_haddr", bus.HADDR, 32'h204);
        check_output("err_bubble_hwdata", bus.HWDATA, 32'h0000_0077);
        check_output("err_r0_valid", 32'(rsp_valid), 32'd1);
        check_output("err_r0_err", 32'(rsp_err), 32'd0);
        check_output("err_r0_write", 32'(rsp_write), 32'd1);
        tick();
        check_output("err_r1_valid", 32'(rsp_valid), 32'd1);
        check_output("err_r1_err", 32'(rsp_err), 32'd1);
        check_output("err_r1_rdata", rsp_rdata, 32'h0);
        tick();
        check_output("err_r2_valid", 32'(rsp_valid), 32'd1);
        check_output("err_r2_err", 32'(rsp_err), 32'd0);
        check_output("err_r2_rdata", rsp_rdata, 32'hCAFE_F00D);
        tick();
        check_output("err_end_valid", 32'(rsp_valid), 32'd0);

        $display("[TB] fill FIFO under HREADY low");
        bus.HREADY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 32'h300 + 32'(4 * accepted), 1'b0, HSIZE_WORD, 32'h0);
            if (cmd_ready) begin
                accepted++;
            end
            tick();
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, HSIZE_BYTE, 32'h0);
        check_output("full_accepted", 32'(accepted), 32'd4);
        check_output("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check_output("full_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        bus.HREADY = 1'b1;
        tick();
        check_output("pop_cmd_ready", 32'(cmd_ready), 32'd1);
        check_output("pop_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        check_output("pop_haddr", bus.HADDR, 32'h300);

        $display("[TB] reset with commands queued");
        HRESET = 1'b1;
        tick();
        check_output("flush_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        check_output("flush_cmd_ready", 32'(cmd_ready), 32'd0);
        check_output("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("flush_haddr", bus.HADDR, 32'h0);
        HRESET = 1'b0;
        tick();
        check_output("flush_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_output("flush_quiet_rsp", 32'(rsp_valid), 32'd0);
            check_output("flush_quiet_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
